mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// Shares one single-port synchronous RAM (altsyncram, registered address, read data
// MEM_LATENCY cycles later) between the pipeline fetch stage (read-only) and the
// memory stage (LDR/STR), replacing the separate instruction/data memories.
// Fixed data priority with a starvation cap for fetch; sequences each access through
// issue, latency wait and response, and discards fetches squashed by a taken branch.
// PARAMETERS
// ADDR_W        11   word address width of the shared RAM
// DATA_W        32   data word width
// MEM_LATENCY   1    cycles from RAM address sample to valid mem_q (1..3)
// STARVE_LIMIT  2    max consecutive data grants while if_req is pending (>=1)
// PORTS
// clk          in   1       single clock, rising edge
// rst_n        in   1       asynchronous active-low reset
// if_req       in   1       fetch request; held with if_addr until if_valid or if_flush
// if_addr      in   ADDR_W  fetch word address
// if_flush     in   1       taken branch: squash outstanding fetch
// if_rdata     out  DATA_W  fetched instruction, valid while if_valid
// if_valid     out  1       one-cycle fetch completion pulse
// d_req        in   1       data request; held with d_wen/d_addr/d_wdata until d_valid
// d_wen        in   1       1 = STR (write), 0 = LDR (read)
// d_addr       in   ADDR_W  data word address
// d_wdata      in   DATA_W  store data
// d_rdata      out  DATA_W  load data, valid while d_valid
// d_valid      out  1       one-cycle data completion pulse (reads and writes)
// mem_addr     out  ADDR_W  RAM address (registered)
// mem_wdata    out  DATA_W  RAM write data (registered)
// mem_wren     out  1       RAM write enable (registered)
// mem_q        in   DATA_W  RAM read data
// arb_state    out  2       current state encoding, debug/status
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; if_valid=d_valid=mem_wren=0; mem_addr=0;
//   mem_wdata=0; if_rdata=d_rdata=0; streak=0; owner=none; squash=0. Mid-access reset aborts; no write lands.
// - States: IDLE(0) -> ACCESS(1) -> WAIT(2, MEM_LATENCY cycles) -> RESP(3) -> IDLE.
// - IDLE: requests sampled only here. Grant data if d_req and !(if_req && streak==STARVE_LIMIT);
//   else grant fetch if if_req; else stay. Winner's addr/wdata/wen registered onto mem_*.
// - ACCESS: mem_wren=d_wen for data owner, 0 otherwise; exactly one cycle. RAM samples address.
// - WAIT: latency counter loads MEM_LATENCY-1, decrements; on 0 capture mem_q into owner's
//   rdata (data writes leave d_rdata unchanged) and go RESP. mem_wren=0.
// - RESP: owner's valid=1 for one cycle; owner cleared; return IDLE. Requester may change
//   or drop req at the edge ending RESP; arbiter re-samples in following IDLE.
// - Latency: grant cycle (IDLE) to valid pulse = MEM_LATENCY+2 cycles; access period MEM_LATENCY+3.
// - streak: +1 (saturating at STARVE_LIMIT) on data grant; cleared on fetch grant or in IDLE with !if_req.
// - if_flush: in IDLE, no effect. During ACCESS/WAIT/RESP of a fetch, sets squash;
//   that fetch's if_valid is suppressed and if_rdata not updated; squash cleared in IDLE.
//   Flush during a data access has no effect on it. Requester re-asserts if_req with new address.
// - Simultaneous if_req & d_req in IDLE with streak<STARVE_LIMIT: data wins.
// - if_valid and d_valid are never high in the same cycle; mem_wren never high outside ACCESS.
// - No request in IDLE: mem_* hold last values, mem_wren=0.
// TESTING
// 1 Fetch only: if_req, if_addr=5, RAM[5]=0xE3A00001 -> mem_addr=5, if_valid pulse 3 cycles after grant, if_rdata=0xE3A00001.
// 2 Store then load: d_req,d_wen=1,d_addr=29,d_wdata=8 -> mem_wren one cycle, d_valid; then LDR addr 29 -> d_rdata=8.
// 3 Contention: if_req and d_req held together for 8 accesses, STARVE_LIMIT=2 -> grant order D,D,F,D,D,F,D,D.
// 4 Flush: fetch addr 2 granted, if_flush in WAIT -> no if_valid; next fetch addr 5 returns RAM[5] normally.
// 5 Reset mid-write: rst_n low during ACCESS of store to addr 10 (old 0) -> outputs to reset values, RAM[10] unchanged if reset precedes edge; IDLE after release.
// 6 MEM_LATENCY=3: single LDR -> d_valid exactly 5 cycles after grant, data correct.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between instruction fetch and
// the data stage: fixed data priority, bounded fetch starvation, branch squash.
module mem_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [1:0]        arb_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
    localparam logic [1:0]    LAT_LOAD   = 2'(MEM_LATENCY - 1);

    state_e              state_q;
    owner_e              owner_q;
    logic [SW-1:0]       streak_q;
    logic [1:0]          lat_q;
    logic                wen_q;
    logic                squash_q;
    logic                if_valid_q;
    logic                d_valid_q;
    logic                mem_wren_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;

    logic starved;
    logic grantData;
    logic grantFetch;
    logic fetchFlush;

    // Data wins unless fetch has already lost STARVE_LIMIT grants in a row.
    assign starved    = if_req && (streak_q == STREAK_MAX);
    assign grantData  = d_req && !starved;
    assign grantFetch = if_req && !grantData;
    assign fetchFlush = if_flush && (owner_q == OWN_FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            streak_q    <= '0;
            lat_q       <= '0;
            wen_q       <= 1'b0;
            squash_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            mem_wren_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            mem_wren_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    squash_q <= 1'b0;
                    owner_q  <= OWN_NONE;
                    if (!if_req) begin
                        streak_q <= '0;
                    end else if (grantData) begin
                        if (streak_q != STREAK_MAX) streak_q <= streak_q + 1'b1;
                    end else if (grantFetch) begin
                        streak_q <= '0;
                    end
                    if (grantData) begin
                        owner_q     <= OWN_DATA;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        mem_wren_q  <= d_wen;
                        wen_q       <= d_wen;
                        state_q     <= ACCESS;
                    end else if (grantFetch) begin
                        owner_q    <= OWN_FETCH;
                        mem_addr_q <= if_addr;
                        wen_q      <= 1'b0;
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (fetchFlush) squash_q <= 1'b1;
                    lat_q   <= LAT_LOAD;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (fetchFlush) squash_q <= 1'b1;
                    if (lat_q == 2'd0) begin
                        state_q <= RESP;
                        if (owner_q == OWN_DATA) begin
                            if (!wen_q) d_rdata_q <= mem_q;
                            d_valid_q <= 1'b1;
                        end else if (!(squash_q || fetchFlush)) begin
                            if_rdata_q <= mem_q;
                            if_valid_q <= 1'b1;
                        end
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                RESP: begin
                    if (fetchFlush) squash_q <= 1'b1;
                    owner_q <= OWN_NONE;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A branch taken during the response cycle still kills the fetch pulse.
    assign if_valid  = if_valid_q && !(if_flush && state_q == RESP);
    assign if_rdata  = if_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wren  = mem_wren_q;
    assign arb_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at latency 1, one at latency 3,
// each backed by a small behavioural synchronous RAM.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        preload;

    logic        ifReq, ifFlush, ifValid, dReq, dWen, dValid, memWren;
    logic [10:0] ifAddr, dAddr, memAddr;
    logic [31:0] ifRdata, dWdata, dRdata, memWdata, memQ;
    logic [1:0]  arbState;

    logic        ifReq3, ifFlush3, ifValid3, dReq3, dWen3, dValid3, memWren3;
    logic [10:0] ifAddr3, dAddr3, memAddr3;
    logic [31:0] ifRdata3, dWdata3, dRdata3, memWdata3, memQ3;
    logic [1:0]  arbState3;

    logic [31:0] ram1 [0:63];
    logic [31:0] ram3 [0:63];
    logic [31:0] r1, r2;

    int total;
    int passed;
    int failed;

    mem_arbiter #(.ADDR_W(11), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(2)) u1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(ifReq), .if_addr(ifAddr), .if_flush(ifFlush),
        .if_rdata(ifRdata), .if_valid(ifValid),
        .d_req(dReq), .d_wen(dWen), .d_addr(dAddr), .d_wdata(dWdata),
        .d_rdata(dRdata), .d_valid(dValid),
        .mem_addr(memAddr), .mem_wdata(memWdata), .mem_wren(memWren),
        .mem_q(memQ), .arb_state(arbState)
    );

    mem_arbiter #(.ADDR_W(11), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(2)) u3 (
        .clk(clk), .rst_n(rst_n),
        .if_req(ifReq3), .if_addr(ifAddr3), .if_flush(ifFlush3),
        .if_rdata(ifRdata3), .if_valid(ifValid3),
        .d_req(dReq3), .d_wen(dWen3), .d_addr(dAddr3), .d_wdata(dWdata3),
        .d_rdata(dRdata3), .d_valid(dValid3),
        .mem_addr(memAddr3), .mem_wdata(memWdata3), .mem_wren(memWren3),
        .mem_q(memQ3), .arb_state(arbState3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latency-1 RAM: address sampled at the edge, data visible the next cycle.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) ram1[i] <= 32'h0;
            ram1[5] <= 32'hE3A00001;
            ram1[2] <= 32'h12345678;
        end else if (memWren) begin
            ram1[memAddr[5:0]] <= memWdata;
        end
        memQ <= ram1[memAddr[5:0]];
    end

    // Latency-3 RAM: two extra output pipeline stages.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) ram3[i] <= 32'h0;
            ram3[7] <= 32'hCAFEF00D;
        end else if (memWren3) begin
            ram3[memAddr3[5:0]] <= memWdata3;
        end
        r1    <= ram3[memAddr3[5:0]];
        r2    <= r1;
        memQ3 <= r2;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int          n;
        int          pulses;
        int          cyc;
        logic        both;
        logic [7:0]  order;

        total = 0; passed = 0; failed = 0;
        rst_n = 1'b0; preload = 1'b1;
        ifReq = 0; ifFlush = 0; ifAddr = '0; dReq = 0; dWen = 0; dAddr = '0; dWdata = '0;
        ifReq3 = 0; ifFlush3 = 0; ifAddr3 = '0; dReq3 = 0; dWen3 = 0; dAddr3 = '0; dWdata3 = '0;

        applyStimulus(2);
        checkOutput("reset_state", {30'b0, arbState}, 32'd0);
        checkOutput("reset_mem_addr", {21'b0, memAddr}, 32'd0);
        checkOutput("reset_if_rdata", ifRdata, 32'd0);
        checkOutput("reset_valids", {30'b0, ifValid, dValid}, 32'd0);
        preload = 1'b0;
        rst_n   = 1'b1;
        applyStimulus(1);

        // Fetch only from address 5.
        ifReq = 1; ifAddr = 11'd5;
        applyStimulus(1);
        checkOutput("f_access_state", {30'b0, arbState}, 32'd1);
        checkOutput("f_mem_addr", {21'b0, memAddr}, 32'd5);
        checkOutput("f_no_wren", {31'b0, memWren}, 32'd0);
        applyStimulus(1);
        checkOutput("f_wait_state", {30'b0, arbState}, 32'd2);
        checkOutput("f_no_early_valid", {31'b0, ifValid}, 32'd0);
        applyStimulus(1);
        checkOutput("f_valid", {31'b0, ifValid}, 32'd1);
        checkOutput("f_rdata", ifRdata, 32'hE3A00001);
        ifReq = 0;
        applyStimulus(1);
        checkOutput("f_valid_one_cycle", {31'b0, ifValid}, 32'd0);
        checkOutput("f_back_idle", {30'b0, arbState}, 32'd0);

        // Store 8 to address 29, then load it back.
        dReq = 1; dWen = 1; dAddr = 11'd29; dWdata = 32'd8;
        applyStimulus(1);
        checkOutput("st_wren", {31'b0, memWren}, 32'd1);
        checkOutput("st_addr", {21'b0, memAddr}, 32'd29);
        checkOutput("st_wdata", memWdata, 32'd8);
        applyStimulus(1);
        checkOutput("st_wren_drop", {31'b0, memWren}, 32'd0);
        applyStimulus(1);
        checkOutput("st_valid", {31'b0, dValid}, 32'd1);
        checkOutput("st_rdata_kept", dRdata, 32'd0);
        dReq = 0;
        applyStimulus(1);
        checkOutput("st_ram_written", ram1[29], 32'd8);
        dReq = 1; dWen = 0;
        applyStimulus(3);
        checkOutput("ld_valid", {31'b0, dValid}, 32'd1);
        checkOutput("ld_rdata", dRdata, 32'd8);
        dReq = 0;
        applyStimulus(1);

        // Contention: both requesters held for eight accesses.
        dReq = 1; dWen = 0; dAddr = 11'd29; ifReq = 1; ifAddr = 11'd5;
        pulses = 0; cyc = 0; both = 0; order = '0;
        while (pulses < 8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ifValid && dValid) both = 1;
            if (dValid) begin
                order = {order[6:0], 1'b1};
                pulses++;
            end else if (ifValid) begin
                order = {order[6:0], 1'b0};
                pulses++;
            end
        end
        ifReq = 0; dReq = 0;
        checkOutput("cont_pulses", pulses, 32'd8);
        checkOutput("cont_order", {24'b0, order}, 32'h000000DB);
        checkOutput("cont_cycles", cyc, 32'd31);
        checkOutput("cont_no_overlap", {31'b0, both}, 32'd0);
        applyStimulus(1);

        // Flush a fetch of address 2 during WAIT, then refetch address 5.
        ifReq = 1; ifAddr = 11'd2;
        applyStimulus(2);
        checkOutput("fl_in_wait", {30'b0, arbState}, 32'd2);
        ifFlush = 1; ifReq = 0;
        applyStimulus(1);
        checkOutput("fl_resp_state", {30'b0, arbState}, 32'd3);
        checkOutput("fl_no_valid", {31'b0, ifValid}, 32'd0);
        checkOutput("fl_rdata_kept", ifRdata, 32'hE3A00001);
        ifFlush = 0;
        applyStimulus(1);
        checkOutput("fl_idle_no_valid", {29'b0, arbState, ifValid}, 32'd0);
        ifReq = 1; ifAddr = 11'd5;
        applyStimulus(3);
        checkOutput("fl_refetch_valid", {31'b0, ifValid}, 32'd1);
        checkOutput("fl_refetch_rdata", ifRdata, 32'hE3A00001);
        ifReq = 0;
        applyStimulus(1);

        // Reset asserted in the ACCESS cycle of a store to address 10.
        dReq = 1; dWen = 1; dAddr = 11'd10; dWdata = 32'hDEADBEEF;
        applyStimulus(1);
        checkOutput("rst_pre_wren", {31'b0, memWren}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_wren", {31'b0, memWren}, 32'd0);
        checkOutput("rst_addr", {21'b0, memAddr}, 32'd0);
        checkOutput("rst_wdata", memWdata, 32'd0);
        checkOutput("rst_state", {30'b0, arbState}, 32'd0);
        applyStimulus(1);
        dReq = 0; dWen = 0;
        rst_n = 1'b1;
        checkOutput("rst_ram_untouched", ram1[10], 32'd0);
        applyStimulus(1);
        checkOutput("rst_idle_after", {29'b0, arbState, memWren}, 32'd0);

        // Latency-3 instance: single load from address 7.
        dReq3 = 1; dWen3 = 0; dAddr3 = 11'd7;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (dValid3) break;
        end
        dReq3 = 0;
        checkOutput("lat3_cycles", n, 32'd5);
        checkOutput("lat3_rdata", dRdata3, 32'hCAFEF00D);
        applyStimulus(1);
        checkOutput("lat3_valid_drop", {31'b0, dValid3}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
